// File: rtl/cnn_seq_pkg.sv
// cnn_seq_pkg
// Shared definitions for the CNN frame sequencer:
//   - seq_state_t      : sequencer FSM states
//   - pixels_per_image : pixels in one square image
//   - cnt_width        : bits needed for a counter that runs 0 .. n-1 (minimum 1)
package cnn_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        FLUSH  = 2'd3
    } seq_state_t;

    // Pixel count of a square image of the given side length.
    function automatic int unsigned pixels_per_image(input int unsigned side);
        return side * side;
    endfunction

    // Width of a counter whose terminal value is n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cnn_seq_result_buf.sv
// cnn_seq_result_buf
// Single-entry valid/ready holding register for one DNN result and its tag.
// A load always wins; the entry otherwise clears when the consumer takes it.
// Ports:
//   clk, res_n        clock, asynchronous active-low reset
//   load              capture load_data/load_tag this cycle
//   load_data         result word(s) to capture
//   load_tag          image index to capture
//   ready             consumer accepts the held entry
//   valid, data, tag  held entry (registered)
//   free_c            entry is empty or is being drained this cycle (combinational)
module cnn_seq_result_buf #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned TagWidth  = 2
) (
    input  logic                 clk,
    input  logic                 res_n,
    input  logic                 load,
    input  logic [DataWidth-1:0] load_data,
    input  logic [TagWidth-1:0]  load_tag,
    input  logic                 ready,
    output logic                 valid,
    output logic [DataWidth-1:0] data,
    output logic [TagWidth-1:0]  tag,
    output logic                 free_c
);

    // Free when empty or when the held entry leaves on this edge.
    assign free_c = !valid || ready;

    // Holding register.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            valid <= 1'b0;
            data  <= '0;
            tag   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            tag   <= load_tag;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cnn_frame_sequencer.sv
// cnn_frame_sequencer
// Sits in front of the conv/pooling + DNN datapath. Streams exactly one image
// of PixelsPerImage pixels at a time from a valid/ready source into the
// datapath, waits for the DNN result, parks it in a single-entry buffer tagged
// with its image index, and pulses the datapath reset (top_res_n) after
// NumImages images, on datapath done, or on a result timeout.
//
// Ports:
//   clk, res_n                   clock, asynchronous active-low reset
//   src_valid, src_data          pixel source
//   src_ready                    pixel accepted (combinational: STREAM & top_out_ready)
//   top_in_valid, top_in_data    registered pixel to datapath (1 cycle after accept)
//   top_out_ready                datapath can take a pixel
//   top_out_valid, top_out_data  datapath result pulse and payload
//   top_out_done                 datapath batch complete
//   top_res_n                    registered active-low flush reset to datapath
//   res_valid, res_data, res_tag buffered result for the consumer
//   res_ready                    consumer accepts the result
//   busy                         sequencer not idle
//   err_timeout                  sticky: no result within TimeoutCycles of DRAIN
//   perf_latency                 (only with CNN_SEQ_PERF_EN) cycles from last
//                                accepted pixel to result capture
//
// Build option: define CNN_SEQ_PERF_EN to add the perf_latency port.
module cnn_frame_sequencer
    import cnn_seq_pkg::*;
#(
    parameter int unsigned BitSize       = 32,
    parameter int unsigned ImageWidth    = 8,
    parameter int unsigned NumOut        = 2,
    parameter int unsigned NumImages     = 4,
    parameter int unsigned FlushCycles   = 4,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                         clk,
    input  logic                         res_n,
    input  logic                         src_valid,
    input  logic [BitSize-1:0]           src_data,
    output logic                         src_ready,
    output logic                         top_in_valid,
    output logic [BitSize-1:0]           top_in_data,
    input  logic                         top_out_ready,
    input  logic                         top_out_valid,
    input  logic [NumOut*BitSize-1:0]    top_out_data,
    input  logic                         top_out_done,
    output logic                         top_res_n,
    output logic                         res_valid,
    output logic [NumOut*BitSize-1:0]    res_data,
    output logic [cnt_width(NumImages)-1:0] res_tag,
    input  logic                         res_ready,
    output logic                         busy,
    output logic                         err_timeout
`ifdef CNN_SEQ_PERF_EN
    ,
    output logic [31:0]                  perf_latency
`endif
);

    localparam int unsigned PixCount = pixels_per_image(ImageWidth);
    localparam int unsigned PixW     = cnt_width(PixCount);
    localparam int unsigned TagW     = cnt_width(NumImages);
    localparam int unsigned WaitW    = cnt_width(TimeoutCycles);
    localparam int unsigned FlushW   = cnt_width(FlushCycles);
    localparam int unsigned ResW     = NumOut * BitSize;

    localparam logic [PixW-1:0]   PixLast   = PixW'(PixCount - 1);
    localparam logic [TagW-1:0]   ImgLast   = TagW'(NumImages - 1);
    localparam logic [WaitW-1:0]  WaitLast  = WaitW'(TimeoutCycles - 1);
    localparam logic [FlushW-1:0] FlushLast = FlushW'(FlushCycles - 1);

    seq_state_t        state;
    seq_state_t        next_state;

    logic [PixW-1:0]   pix_cnt;
    logic [TagW-1:0]   img_cnt;
    logic [WaitW-1:0]  wait_cnt;
    logic [FlushW-1:0] flush_cnt;
    logic              done_seen;

    logic              fire_c;
    logic              last_pix_c;
    logic              capture_c;
    logic              timeout_c;
    logic              flush_end_c;
    logic              batch_end_c;
    logic              buf_free_c;

    // State register. Reset itself acts as the flush: top_res_n is held low
    // while res_n is low and the FSM starts in IDLE once it is released.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A batch ends on the last image slot or on done seen at any point in DRAIN.
    assign batch_end_c = (img_cnt == ImgLast) || done_seen || top_out_done;

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (src_valid && buf_free_c) begin
                    next_state = STREAM;
                end
            end
            STREAM: begin
                if (last_pix_c) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (capture_c) begin
                    next_state = batch_end_c ? FLUSH : IDLE;
                end else if (timeout_c) begin
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_end_c) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Per-state strobes and the combinational source handshake.
    always_comb begin
        src_ready   = 1'b0;
        fire_c      = 1'b0;
        last_pix_c  = 1'b0;
        capture_c   = 1'b0;
        timeout_c   = 1'b0;
        flush_end_c = 1'b0;
        case (state)
            STREAM: begin
                src_ready  = top_out_ready;
                fire_c     = src_valid && top_out_ready;
                last_pix_c = fire_c && (pix_cnt == PixLast);
            end
            DRAIN: begin
                capture_c = top_out_valid;
                timeout_c = !top_out_valid && (wait_cnt == WaitLast);
            end
            FLUSH: begin
                flush_end_c = (flush_cnt == FlushLast);
            end
            default: ;
        endcase
    end

    // Pixel pipe, counters and status flags.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            top_in_valid <= 1'b0;
            top_in_data  <= '0;
            pix_cnt      <= '0;
            img_cnt      <= '0;
            wait_cnt     <= '0;
            flush_cnt    <= '0;
            done_seen    <= 1'b0;
            err_timeout  <= 1'b0;
            top_res_n    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            top_in_valid <= fire_c;
            if (fire_c) begin
                top_in_data <= src_data;
            end

            if (last_pix_c) begin
                pix_cnt <= '0;
            end else if (fire_c) begin
                pix_cnt <= pix_cnt + PixW'(1);
            end

            // Holds at the last slot; cleared when the flush completes.
            if ((state == FLUSH) && flush_end_c) begin
                img_cnt <= '0;
            end else if (capture_c && (img_cnt != ImgLast)) begin
                img_cnt <= img_cnt + TagW'(1);
            end

            // Counts DRAIN cycles only; saturates at the timeout value.
            if (state != DRAIN) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WaitLast) begin
                wait_cnt <= wait_cnt + WaitW'(1);
            end

            if (state != FLUSH) begin
                flush_cnt <= '0;
            end else if (!flush_end_c) begin
                flush_cnt <= flush_cnt + FlushW'(1);
            end

            // Remembers done from earlier DRAIN cycles of the current image.
            if (state != DRAIN) begin
                done_seen <= 1'b0;
            end else if (top_out_done) begin
                done_seen <= 1'b1;
            end

            if (timeout_c) begin
                err_timeout <= 1'b1;
            end

            // Registered from next_state so both track the state register exactly.
            top_res_n <= (next_state != FLUSH);
            busy      <= (next_state != IDLE);
        end
    end

`ifdef CNN_SEQ_PERF_EN
    // Latency = DRAIN cycles elapsed plus the capture cycle itself.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            perf_latency <= '0;
        end else if (capture_c) begin
            perf_latency <= 32'(wait_cnt) + 32'd1;
        end
    end
`endif

    // Result holding register; only DRAIN captures, so stray pulses are ignored.
    cnn_seq_result_buf #(
        .DataWidth (ResW),
        .TagWidth  (TagW)
    ) u_result_buf (
        .clk       (clk),
        .res_n     (res_n),
        .load      (capture_c),
        .load_data (top_out_data),
        .load_tag  (img_cnt),
        .ready     (res_ready),
        .valid     (res_valid),
        .data      (res_data),
        .tag       (res_tag),
        .free_c    (buf_free_c)
    );

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// Self-checking bench for cnn_frame_sequencer: randomized images, a batch
// model (image index, flush events) and scoreboards for pixels and results.
module tb_cnn_frame_sequencer;

    localparam int unsigned BitSize       = 32;
    localparam int unsigned ImageWidth    = 8;
    localparam int unsigned NumOut        = 2;
    localparam int unsigned NumImages     = 4;
    localparam int unsigned FlushCycles   = 4;
    localparam int unsigned TimeoutCycles = 1024;
    localparam int unsigned Pix           = ImageWidth * ImageWidth;
    localparam int unsigned ResW          = NumOut * BitSize;

    typedef struct packed {
        logic [ResW-1:0] data;
        logic [1:0]      tag;
    } res_t;

    logic               clk;
    logic               res_n;
    logic               src_valid;
    logic [BitSize-1:0] src_data;
    logic               src_ready;
    logic               top_in_valid;
    logic [BitSize-1:0] top_in_data;
    logic               top_out_ready;
    logic               top_out_valid;
    logic [ResW-1:0]    top_out_data;
    logic               top_out_done;
    logic               top_res_n;
    logic               res_valid;
    logic [ResW-1:0]    res_data;
    logic [1:0]         res_tag;
    logic               res_ready;
    logic               busy;
    logic               err_timeout;
`ifdef CNN_SEQ_PERF_EN
    logic [31:0]        perf_latency;
`endif

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;      // 0: always ready, 1: toggle, 2: random
    int rr_mode = 0;       // 0: always ready, 1: held low, 2: random
    int img_idx = 0;       // model: index of next image within its batch
    int exp_flushes = 0;
    int seen_flushes = 0;

    logic [BitSize-1:0] exp_pix[$];
    res_t               exp_res[$];

    cnn_frame_sequencer #(
        .BitSize       (BitSize),
        .ImageWidth    (ImageWidth),
        .NumOut        (NumOut),
        .NumImages     (NumImages),
        .FlushCycles   (FlushCycles),
        .TimeoutCycles (TimeoutCycles)
    ) dut (
        .clk           (clk),
        .res_n         (res_n),
        .src_valid     (src_valid),
        .src_data      (src_data),
        .src_ready     (src_ready),
        .top_in_valid  (top_in_valid),
        .top_in_data   (top_in_data),
        .top_out_ready (top_out_ready),
        .top_out_valid (top_out_valid),
        .top_out_data  (top_out_data),
        .top_out_done  (top_out_done),
        .top_res_n     (top_res_n),
        .res_valid     (res_valid),
        .res_data      (res_data),
        .res_tag       (res_tag),
        .res_ready     (res_ready),
        .busy          (busy),
        .err_timeout   (err_timeout)
`ifdef CNN_SEQ_PERF_EN
        ,
        .perf_latency  (perf_latency)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_top_in_valid"}, 64'(top_in_valid), 64'd0);
        chk({tag, "_top_in_data"},  64'(top_in_data),  64'd0);
        chk({tag, "_res_valid"},    64'(res_valid),    64'd0);
        chk({tag, "_res_data"},     64'(res_data),     64'd0);
        chk({tag, "_res_tag"},      64'(res_tag),      64'd0);
        chk({tag, "_err_timeout"},  64'(err_timeout),  64'd0);
        chk({tag, "_top_res_n"},    64'(top_res_n),    64'd0);
        chk({tag, "_src_ready"},    64'(src_ready),    64'd0);
        chk({tag, "_busy"},         64'(busy),         64'd0);
    endtask

    // Datapath-side handshake drivers, updated just after each active edge.
    initial begin
        top_out_ready = 1'b1;
        res_ready     = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       top_out_ready = 1'b1;
                1:       top_out_ready = !top_out_ready;
                default: top_out_ready = ($urandom_range(0, 3) != 0);
            endcase
            case (rr_mode)
                0:       res_ready = 1'b1;
                1:       res_ready = 1'b0;
                default: res_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Pixel monitor: each accepted pixel must reappear on top_in one cycle later, in order.
    initial begin : pix_mon
        logic fire_prev;
        fire_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!res_n) begin
                fire_prev = 1'b0;
            end else begin
                if (top_in_valid || fire_prev)
                    chk("top_in_valid_latency", 64'(top_in_valid), 64'(fire_prev));
                if (top_in_valid) begin
                    if (exp_pix.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL top_in_data: unexpected pixel %0h with nothing outstanding", top_in_data);
                    end else begin
                        chk("top_in_data", 64'(top_in_data), 64'(exp_pix.pop_front()));
                    end
                end
                if (src_ready)
                    chk("src_ready_needs_top_out_ready", 64'(top_out_ready), 64'd1);
                fire_prev = src_valid && src_ready;
            end
        end
    end

    // Result monitor: compares each consumed result and checks a held result stays put.
    initial begin : res_mon
        logic            hold_prev;
        logic [ResW-1:0] data_prev;
        res_t            e;
        hold_prev = 1'b0;
        data_prev = '0;
        forever begin
            @(negedge clk);
            if (!res_n) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    chk("res_hold_valid", 64'(res_valid), 64'd1);
                    chk("res_hold_data",  64'(res_data),  64'(data_prev));
                end
                if (res_valid && res_ready) begin
                    if (exp_res.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL res_unexpected: got data %0h tag %0d with nothing outstanding", res_data, res_tag);
                    end else begin
                        e = exp_res.pop_front();
                        chk("res_data", 64'(res_data), 64'(e.data));
                        chk("res_tag",  64'(res_tag),  64'(e.tag));
                    end
                end
                hold_prev = res_valid && !res_ready;
                data_prev = res_data;
            end
        end
    end

    // Flush monitor: every flush not caused by res_n holds top_res_n low exactly FlushCycles.
    initial begin : flush_mon
        int   low_run;
        logic rst_run;
        low_run = 0;
        rst_run = 1'b0;
        forever begin
            @(negedge clk);
            if (!res_n) begin
                rst_run = 1'b1;
                low_run = 0;
            end else if (!top_res_n) begin
                low_run++;
            end else begin
                if (low_run > 0 && !rst_run) begin
                    chk("flush_len", 64'(low_run), 64'(FlushCycles));
                    seen_flushes++;
                end
                low_run = 0;
                rst_run = 1'b0;
            end
        end
    end

    // Streams n_pix pixels, then optionally returns a result after `delay` DRAIN cycles.
    // done_mode: 0 none, 1 done with the result, 2 done pulse in DRAIN cycle 1.
    task automatic run_image(input int n_pix, input bit seq_data, input bit give_result,
                             input int delay, input int done_mode);
        logic [BitSize-1:0] px;
        bit                 ok;
        res_t               r;
        for (int i = 0; i < n_pix; i++) begin
            px = seq_data ? 32'(i) : $urandom;
            src_valid = 1'b1;
            src_data  = px;
            ok = 1'b0;
            for (int w = 0; w < 400 && !ok; w++) begin
                @(negedge clk);
                ok = src_ready;
            end
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL pixel_accept: pixel %0d not accepted within 400 cycles", i);
                src_valid = 1'b0;
                return;
            end
            exp_pix.push_back(px);
            @(posedge clk);
            #1;
        end
        src_valid = 1'b0;
        src_data  = '0;
        if (!give_result) return;
        for (int k = 0; k < delay; k++) begin
            top_out_done = (done_mode == 2 && k == 1);
            @(posedge clk);
            #1;
        end
        r.data = {$urandom, $urandom};
        r.tag  = 2'(img_idx);
        top_out_valid = 1'b1;
        top_out_data  = r.data;
        top_out_done  = (done_mode == 1);
        exp_res.push_back(r);
        if (img_idx == NumImages - 1 || done_mode != 0) begin
            exp_flushes++;
            img_idx = 0;
        end else begin
            img_idx++;
        end
        @(posedge clk);
        #1;
        top_out_valid = 1'b0;
        top_out_done  = 1'b0;
    endtask

    initial begin : main
        int cnt;
        int dm;
        res_n         = 1'b0;
        src_valid     = 1'b0;
        src_data      = '0;
        top_out_valid = 1'b0;
        top_out_data  = '0;
        top_out_done  = 1'b0;

        #12;
        check_reset("rst");
        @(negedge clk);
        #2 res_n = 1'b1;
        @(posedge clk);
        #1;
        chk("top_res_n_release", 64'(top_res_n), 64'd1);
        chk("busy_after_release", 64'(busy), 64'd0);

        // Image 0: steady ready, result at DRAIN cycle 5, sequential pixels.
        run_image(Pix, 1'b1, 1'b1, 5, 0);
        chk("img0_res_valid", 64'(res_valid), 64'd1);
        chk("img0_res_tag",   64'(res_tag),   64'd0);
        chk("img0_busy_idle", 64'(busy),      64'd0);

        // Image 1: top_out_ready toggles every cycle.
        rdy_mode = 1;
        run_image(Pix, 1'b1, 1'b1, 2 + $urandom_range(0, 8), 0);

        // Images 2 and 3: random ready; the 4th result closes the batch.
        rdy_mode = 2;
        run_image(Pix, 1'b0, 1'b1, $urandom_range(0, 12), 0);
        run_image(Pix, 1'b0, 1'b1, $urandom_range(0, 12), 0);
        repeat (8) @(negedge clk);
        chk("flush_after_batch", 64'(seen_flushes), 64'(exp_flushes));

        // Next batch starts at tag 0.
        rdy_mode = 0;
        run_image(Pix, 1'b0, 1'b1, 3, 0);
        repeat (3) @(posedge clk);

        // Consumer stalls: result held, no new image may start.
        rr_mode = 1;
        run_image(Pix, 1'b0, 1'b1, 4, 0);
        src_valid = 1'b1;
        src_data  = 32'hA5A5_0000;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (src_ready) cnt++;
        end
        chk("blocked_src_ready", 64'(cnt), 64'd0);
        chk("blocked_busy", 64'(busy), 64'd0);
        chk("blocked_res_valid", 64'(res_valid), 64'd1);
        rr_mode = 0;
        // Done seen early in DRAIN forces a flush before the batch is full.
        run_image(Pix, 1'b0, 1'b1, 6, 2);
        repeat (6) @(posedge clk);
        #1;

        // Stray result pulse in IDLE must be ignored.
        top_out_valid = 1'b1;
        top_out_data  = {$urandom, $urandom};
        @(posedge clk);
        #1;
        top_out_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("stray_ignored", 64'(res_valid), 64'd0);

        // Timeout: no result at all.
        run_image(Pix, 1'b0, 1'b0, 0, 0);
        exp_flushes++;
        img_idx = 0;
        cnt = 0;
        repeat (TimeoutCycles) begin
            @(negedge clk);
            if (err_timeout) cnt++;
        end
        chk("timeout_not_early", 64'(cnt), 64'd0);
        @(negedge clk);
        chk("timeout_flag", 64'(err_timeout), 64'd1);
        chk("timeout_flush", 64'(top_res_n), 64'd0);
        repeat (10) @(negedge clk);
        chk("timeout_sticky", 64'(err_timeout), 64'd1);
        chk("timeout_back_idle", 64'(busy), 64'd0);

        // Asynchronous reset mid-image.
        run_image(30, 1'b0, 1'b0, 0, 0);
        chk("sticky_pre_reset", 64'(err_timeout), 64'd1);
        #2 res_n = 1'b0;
        src_valid = 1'b0;
        #1;
        check_reset("mid_rst");
        exp_pix.delete();
        img_idx = 0;
        repeat (2) @(negedge clk);
        #2 res_n = 1'b1;
        run_image(Pix, 1'b0, 1'b1, 5, 0);
        chk("after_rst_tag", 64'(res_tag), 64'd0);

        // Randomized tail.
        rdy_mode = 2;
        rr_mode  = 2;
        for (int n = 0; n < 8; n++) begin
            dm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            run_image(Pix, 1'b0, 1'b1, 3 + $urandom_range(0, 17), dm);
        end
        rr_mode = 0;
        repeat (30) @(negedge clk);

        chk("pix_queue_empty", 64'(exp_pix.size()), 64'd0);
        chk("res_queue_empty", 64'(exp_res.size()), 64'd0);
        chk("flush_count", 64'(seen_flushes), 64'(exp_flushes));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnn_frame_sequencer.md
Name: cnn_frame_sequencer

Overview:
- Controller placed in front of the conv/pooling + DNN top.
- Accepts pixel frames from a valid/ready source and streams exactly one image into the datapath at a time, honouring the datapath's out_ready.
- Waits for the DNN result, buffers it for a downstream consumer and tags it with its image index.
- After NumImages images, or when the datapath reports done, pulses a flush reset, because the datapath processes only a fixed number of images before it must be reset.

Parameters:
- BitSize, 32, pixel and result word width.
- ImageWidth, 8, image side length; PixelsPerImage = ImageWidth*ImageWidth.
- NumOut, 2, result words per image (DNN final-layer neuron count).
- NumImages, 4, images per batch before a forced flush.
- FlushCycles, 4, cycles top_res_n is held low during a flush.
- TimeoutCycles, 1024, maximum DRAIN wait for a result.

Ports:
- clk  in  1  clock.
- res_n  in  1  asynchronous active-low reset.
- src_valid  in  1  source pixel valid.
- src_data  in  BitSize  source pixel.
- src_ready  out  1  sequencer accepts a pixel.
- top_in_valid  out  1  pixel valid to datapath.
- top_in_data  out  BitSize  pixel to datapath.
- top_out_ready  in  1  datapath can accept a pixel.
- top_out_valid  in  1  datapath result pulse.
- top_out_data  in  NumOut*BitSize  datapath result.
- top_out_done  in  1  datapath batch complete.
- top_res_n  out  1  active-low flush reset to datapath.
- res_valid  out  1  buffered result valid.
- res_data  out  NumOut*BitSize  buffered result.
- res_tag  out  clog2(NumImages)  image index of the result within its batch.
- res_ready  in  1  consumer accepts the result.
- busy  out  1  state != IDLE.
- err_timeout  out  1  sticky timeout flag.

Behaviour:
- Reset (res_n low, asynchronous):
  - state = FLUSH-equivalent hold.
  - All counters = 0.
  - top_in_valid = 0, top_in_data = 0.
  - res_valid = 0, res_data = 0, res_tag = 0.
  - err_timeout = 0, top_res_n = 0.
  - After res_n rises, top_res_n goes 1 on the first clk edge; state = IDLE.
- States:
  - IDLE → STREAM when src_valid=1 and the result buffer is free (res_valid=0, or res_valid & res_ready this cycle).
  - STREAM:
    - src_ready = top_out_ready.
    - fire = src_valid & src_ready.
    - top_in_valid <= fire; top_in_data <= src_data (registered, latency 1 cycle).
    - pix_cnt increments on each fire.
    - On the fire with pix_cnt == PixelsPerImage-1: pix_cnt → 0, state → DRAIN.
  - DRAIN:
    - src_ready = 0; wait_cnt increments every cycle.
    - On top_out_valid: res_data <= top_out_data, res_tag <= img_cnt, res_valid <= 1; img_cnt increments.
    - If img_cnt was NumImages-1, or top_out_done=1 in the same or any earlier DRAIN cycle, → FLUSH; otherwise → IDLE.
    - If wait_cnt == TimeoutCycles-1 with no top_out_valid: err_timeout <= 1, → FLUSH.
  - FLUSH:
    - top_res_n = 0 for exactly FlushCycles cycles; src_ready = 0.
    - img_cnt → 0 on exit; state → IDLE.
- src_ready is 0 in every state other than STREAM.
- Result buffer:
  - res_valid clears on res_valid & res_ready.
  - A new image never starts while the buffer is occupied, so a result can never be lost.
  - top_out_valid outside DRAIN is ignored.
- top_out_ready deasserted mid-image: src_ready = 0, pix_cnt holds, no pixel is dropped or duplicated.
- err_timeout clears only on res_n.
- Counter wrap: pix_cnt and img_cnt never exceed their terminal values; wait_cnt saturates.

Optional Feature:
- Macro CNN_SEQ_PERF_EN.
- When defined: adds output port perf_latency [31:0], the cycle count from the last accepted pixel of an image to that image's result capture. It updates at each capture, resets to 0, and holds its value across a flush.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package cnn_seq_pkg holds:
  - the state enum (IDLE, STREAM, DRAIN, FLUSH);
  - a PixelsPerImage localparam function;
  - counter-width helpers (clog2-based).
- One sub-module, cnn_seq_result_buf: single-entry valid/ready holding register with tag.

Test Plan:
- ImageWidth=8, src_valid held 1, top_out_ready=1, result at DRAIN cycle 5, res_ready=1 → 64 top_in_valid pulses, each 1 cycle after its src fire; res_valid=1 with res_tag=0; state returns to IDLE.
- top_out_ready toggles 1/0 every cycle through an image → exactly 64 top_in_valid pulses; data order matches source sequence 0..63.
- 4 consecutive images → res_tag 0,1,2,3; after the 4th result, top_res_n is low for exactly 4 cycles; next image res_tag=0.
- res_ready=0 after image 0's result → src_ready stays 0 (IDLE) until res_ready=1; no overwrite of res_data.
- No top_out_valid in DRAIN → err_timeout=1 at DRAIN cycle 1024; FLUSH follows; flag stays 1 until res_n.
- res_n pulsed low at pixel 30 → all outputs at their reset values immediately; the next image restarts at pix_cnt=0 and res_tag=0.
